eth_rx_framer: RTL

- Ingress framing stage that sits directly upstream of the UDP top-level write port (wr_en/wr_sof/wr_eof/data_din/full).
- Takes a raw byte stream with an end-of-burst marker, hunts for the Ethernet preamble (0x55 repeated, then SFD 0xD5), and strips it.
- Forwards the frame bytes with SOF on the first byte and EOF on the last byte.
- Discards malformed bursts, truncates oversize frames, and keeps saturating frame/drop counters.

---
 rtl/eth_rx_framer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/eth_rx_framer.sv
// Ethernet ingress framer: hunts for 0x55 preamble + 0xD5 SFD, strips it and
// forwards the frame bytes with SOF/EOF into a downstream FIFO write port.
module eth_rx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRE_MIN    = 5,
  parameter int MAX_LEN    = 1518
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  wr_en,
  output logic                  wr_sof,
  output logic                  wr_eof,
  output logic [DATA_WIDTH-1:0] data_din,
  input  logic                  full,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count
);

  localparam logic [DATA_WIDTH-1:0] PRE_BYTE = DATA_WIDTH'(8'h55);
  localparam logic [DATA_WIDTH-1:0] SFD_BYTE = DATA_WIDTH'(8'hD5);
  localparam logic [15:0]           LAST_IDX = 16'(MAX_LEN - 1);
  localparam logic [2:0]            PRE_NEED = 3'(PRE_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_FORWARD,
    S_DRAIN,
    S_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] len_q, len_d;
  logic        first_q, first_d;
  logic [15:0] frame_q, drop_q;
  logic        frame_inc, drop_inc;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    len_d     = len_q;
    first_d   = first_q;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_sof    = 1'b0;
    wr_eof    = 1'b0;
    data_din  = '0;

    if (reset) begin
      unique case (state_q)
        S_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (in_last) begin
              drop_inc = 1'b1;
            end else if (in_data == PRE_BYTE) begin
              state_d   = S_PREAMBLE;
              pre_cnt_d = 3'd1;
            end else begin
              state_d = S_DISCARD;
            end
          end
        end

        S_PREAMBLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (in_last) begin
              state_d  = S_IDLE;
              drop_inc = 1'b1;
            end else if (in_data == PRE_BYTE) begin
              if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
            end else if (in_data == SFD_BYTE && pre_cnt_q >= PRE_NEED) begin
              state_d = S_FORWARD;
              first_d = 1'b1;
              len_d   = '0;
            end else begin
              state_d = S_DISCARD;
            end
          end
        end

        S_FORWARD: begin
          // Only this state stalls on a full FIFO; the write is the handshake.
          in_ready = ~full;
          if (in_valid && !full) begin
            wr_en    = 1'b1;
            data_din = in_data;
            wr_sof   = first_q;
            wr_eof   = in_last | (len_q == LAST_IDX);
            len_d    = len_q + 16'd1;
            first_d  = 1'b0;
            if (in_last) begin
              state_d   = S_IDLE;
              frame_inc = 1'b1;
            end else if (len_q == LAST_IDX) begin
              state_d   = S_DRAIN;
              frame_inc = 1'b1;
            end
          end
        end

        S_DRAIN: begin
          in_ready = 1'b1;
          if (in_valid && in_last) state_d = S_IDLE;
        end

        S_DISCARD: begin
          in_ready = 1'b1;
          if (in_valid && in_last) begin
            state_d  = S_IDLE;
            drop_inc = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      len_q     <= '0;
      first_q   <= 1'b0;
      frame_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      len_q     <= len_d;
      first_q   <= first_d;
      if (frame_inc && frame_q != 16'hFFFF) frame_q <= frame_q + 16'd1;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign frame_count = frame_q;
  assign drop_count  = drop_q;

endmodule
